// File: rtl/obuf_pkg.sv
// Shared constants for the array input and output buffers.
`default_nettype none
package obuf_pkg;
   localparam int BYTE_W     = 8;
   localparam int WORD_BYTES = 4;
   localparam int FILL_W     = $clog2(WORD_BYTES);
   localparam int WORD_W     = BYTE_W * WORD_BYTES;

   localparam int IBUF_DEPTH = 4;
   localparam int IBUF_PTR_W = $clog2(IBUF_DEPTH);
endpackage
`default_nettype wire

// File: rtl/obuffer_col.sv
// Column output buffer: packs result bytes big-endian into words and holds
// one completed word for the downstream memory, flagging dropped words.
`default_nettype none
module obuffer_col
   import obuf_pkg::*;
#(
   parameter int WORD_BYTES = obuf_pkg::WORD_BYTES
) (
   input  logic                         CLK,
   input  logic                         RSTN,
   input  logic                         ENIn,
   input  logic [BYTE_W-1:0]            ID,
   input  logic                         Flush,
   input  logic                         WReady,
   output logic [BYTE_W*WORD_BYTES-1:0] OWord,
   output logic                         WValid,
   output logic [FILL_W-1:0]            Fill,
   output logic                         Busy,
   output logic                         OvfErr
);

   localparam int LW = BYTE_W * WORD_BYTES;

   logic [BYTE_W-1:0] r_bytes [WORD_BYTES-1];
   logic [FILL_W-1:0] r_fill;
   logic [LW-1:0]     r_oword;
   logic              r_wvalid;
   logic              r_ovf;

   logic              w_full_comp;
   logic              w_flush_comp;
   logic              w_comp;
   logic              w_load;
   logic              w_xfer;
   logic              w_store;
   logic [LW-1:0]     w_word;

   assign w_full_comp  = ENIn && (r_fill == FILL_W'(WORD_BYTES - 1));
   assign w_flush_comp = Flush && ((r_fill != '0) || ENIn);
   assign w_comp       = w_full_comp || w_flush_comp;
   assign w_load       = ENIn && !w_comp;
   assign w_xfer       = r_wvalid && WReady;
   // A completion lands only if the holding register is free by this edge.
   assign w_store      = w_comp && (!r_wvalid || w_xfer);

   for (genvar gi = 0; gi < WORD_BYTES - 1; gi++) begin : g_slot
      always_ff @(posedge CLK or negedge RSTN) begin
         if (!RSTN) begin
            r_bytes[gi] <= '0;
         end else if (w_load && (r_fill == FILL_W'(gi))) begin
            r_bytes[gi] <= ID;
         end
      end

      // Filled slots come from the packer, the current slot may take the
      // same-cycle byte, anything beyond is zero.
      assign w_word[LW-1-gi*BYTE_W -: BYTE_W] =
         (FILL_W'(gi) < r_fill)                ? r_bytes[gi] :
         ((FILL_W'(gi) == r_fill) && ENIn)     ? ID          : '0;
   end

   assign w_word[BYTE_W-1:0] = w_full_comp ? ID : '0;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_fill <= '0;
      end else if (w_comp) begin
         r_fill <= '0;
      end else if (ENIn) begin
         r_fill <= r_fill + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_oword  <= '0;
         r_wvalid <= 1'b0;
      end else if (w_store) begin
         r_oword  <= w_word;
         r_wvalid <= 1'b1;
      end else if (w_xfer) begin
         r_wvalid <= 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_ovf <= 1'b0;
      end else if (w_comp && !w_store) begin
         r_ovf <= 1'b1;
      end
   end

   assign OWord  = r_oword;
   assign WValid = r_wvalid;
   assign Fill   = r_fill;
   assign Busy   = (r_fill != '0) || r_wvalid;
   assign OvfErr = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_obuffer_col.sv
// Scoreboard bench for obuffer_col: directed byte streams, monitor checks words.
`default_nettype none
module tb_obuffer_col;

   logic        CLK = 1'b0;
   logic        RSTN = 1'b0;
   logic        ENIn = 1'b0;
   logic [7:0]  ID = 8'h00;
   logic        Flush = 1'b0;
   logic        WReady = 1'b0;
   logic [31:0] OWord;
   logic        WValid;
   logic [1:0]  Fill;
   logic        Busy;
   logic        OvfErr;

   int          total = 0;
   int          bad = 0;
   logic [31:0] q[$];

   obuffer_col #(.WORD_BYTES(4)) dut (
      .CLK(CLK), .RSTN(RSTN), .ENIn(ENIn), .ID(ID), .Flush(Flush),
      .WReady(WReady), .OWord(OWord), .WValid(WValid), .Fill(Fill),
      .Busy(Busy), .OvfErr(OvfErr)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; monitor samples on the falling edge.
   task automatic step(input logic en, input logic [7:0] id, input logic fl, input logic rdy);
      ENIn = en; ID = id; Flush = fl; WReady = rdy;
      @(posedge CLK); #1;
   endtask

   task automatic bytes(input logic [7:0] first, input int n, input logic rdy);
      for (int k = 0; k < n; k++) step(1'b1, first + 8'(k), 1'b0, rdy);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   always @(negedge CLK) begin
      if (RSTN && WValid) begin
         if (q.size() == 0) begin
            chk("unexpected_word", OWord, 32'hxxxxxxxx);
         end else if (WReady) begin
            chk("accepted_word", OWord, q.pop_front());
         end else begin
            chk("held_word", OWord, q[0]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_oword", OWord, 32'h0);
      chk("rst_flags", {28'h0, WValid, Fill, Busy}, 32'h0);
      chk("rst_ovf", {31'h0, OvfErr}, 32'h0);
      RSTN = 1'b1;
      @(posedge CLK); #1;

      // four bytes, one word
      q.push_back(32'h11223344);
      step(1'b1, 8'h11, 1'b0, 1'b1);
      step(1'b1, 8'h22, 1'b0, 1'b1);
      step(1'b1, 8'h33, 1'b0, 1'b1);
      chk("fill_3", {30'h0, Fill}, 32'd3);
      chk("busy_partial", {31'h0, Busy}, 32'd1);
      step(1'b1, 8'h44, 1'b0, 1'b1);
      chk("wvalid_after_4", {31'h0, WValid}, 32'd1);
      chk("fill_after_4", {30'h0, Fill}, 32'd0);
      idle(1);
      chk("wvalid_one_cycle", {31'h0, WValid}, 32'd0);
      chk("busy_idle", {31'h0, Busy}, 32'd0);

      // back-to-back words at full rate
      q.push_back(32'h01020304);
      q.push_back(32'h05060708);
      bytes(8'h01, 8, 1'b1);
      idle(2);
      chk("b2b_drained", q.size(), 32'd0);
      chk("b2b_no_ovf", {31'h0, OvfErr}, 32'd0);

      // partial words via Flush
      q.push_back(32'hAABB0000);
      step(1'b1, 8'hAA, 1'b0, 1'b1);
      step(1'b1, 8'hBB, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      chk("flush_fill0", {30'h0, Fill}, 32'd0);
      idle(1);
      q.push_back(32'hAABBCC00);
      step(1'b1, 8'hAA, 1'b0, 1'b1);
      step(1'b1, 8'hBB, 1'b0, 1'b1);
      step(1'b1, 8'hCC, 1'b1, 1'b1);
      idle(2);
      chk("flush_drained", q.size(), 32'd0);

      // flush when empty is a no-op
      step(1'b0, 8'h00, 1'b1, 1'b1);
      chk("noop_wvalid", {31'h0, WValid}, 32'd0);
      chk("noop_busy", {31'h0, Busy}, 32'd0);

      // overflow: second word dropped while first is held
      q.push_back(32'h01020304);
      bytes(8'h01, 8, 1'b0);
      chk("ovf_set", {31'h0, OvfErr}, 32'd1);
      chk("ovf_held_word", OWord, 32'h01020304);
      chk("ovf_fill0", {30'h0, Fill}, 32'd0);
      idle(1);
      chk("ovf_accepted", {31'h0, WValid}, 32'd0);
      chk("ovf_drained", q.size(), 32'd0);
      idle(2);
      chk("ovf_sticky", {31'h0, OvfErr}, 32'd1);

      // reset mid-operation discards held and partial words
      q.push_back(32'h01020304);
      bytes(8'h01, 4, 1'b0);
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      step(1'b1, 8'hBB, 1'b0, 1'b0);
      chk("pre_rst_fill", {30'h0, Fill}, 32'd2);
      RSTN = 1'b0;
      #1;
      q.delete();
      chk("mid_rst_oword", OWord, 32'h0);
      chk("mid_rst_flags", {28'h0, WValid, Fill, Busy}, 32'h0);
      chk("mid_rst_ovf", {31'h0, OvfErr}, 32'h0);
      @(posedge CLK); #1;
      RSTN = 1'b1;
      q.push_back(32'h01020304);
      bytes(8'h01, 4, 1'b1);
      idle(2);
      chk("post_rst_drained", q.size(), 32'd0);
      chk("post_rst_ovf", {31'h0, OvfErr}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/obuffer_col.md
OBUFFER_COL -- requirements
Module: obuffer_col

Interface
REQ-001 SHALL have parameter WORD_BYTES, default 4, bytes packed per output word; only the value 4 is required to be supported.
REQ-002 SHALL have port CLK  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port RSTN  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ENIn  input  1  byte-valid strobe from the array column bottom (no backpressure to the array).
REQ-005 SHALL have port ID  input  8  result byte, sampled when ENIn=1.
REQ-006 SHALL have port Flush  input  1  single-cycle request to emit a partial word.
REQ-007 SHALL have port WReady  input  1  downstream memory accepts OWord this cycle.
REQ-008 SHALL have port OWord  output  32  packed word, first byte received in [31:24].
REQ-009 SHALL have port WValid  output  1  OWord holds an unaccepted word.
REQ-010 SHALL have port Fill  output  2  bytes currently in the packer (0..3).
REQ-011 SHALL have port Busy  output  1  high when Fill!=0 or WValid=1.
REQ-012 SHALL have port OvfErr  output  1  sticky error: a completed word was dropped.

Function
REQ-013 SHALL hold a packer (3 byte registers plus a fill counter) and one holding register (OWord plus WValid).
REQ-014 SHALL write ID into byte slot Fill on each ENIn=1 edge (slot 0 = [31:24], slot 3 = [7:0]) and increment Fill.
REQ-015 SHALL complete a word when ENIn=1 and Fill=3: the 4th byte goes directly to [7:0] of the word.
REQ-016 SHALL complete a partial word when Flush=1 and (Fill!=0 or ENIn=1): the ENIn byte in that cycle is included, and unfilled low bytes are zero.
REQ-017 SHALL ignore Flush when Fill=0 and ENIn=0 (no-op, no WValid).
REQ-018 SHALL clear Fill to 0 at the edge of any completion, whether or not the word is stored.
REQ-019 SHALL register a completed word into OWord with WValid=1 at the completing edge, so the latency from the final byte's edge to WValid=1 is 0 cycles after that edge (visible the next cycle).
REQ-020 SHALL count a transfer when WValid=1 and WReady=1 at an edge; WValid then falls unless a new word is loaded at the same edge.
REQ-021 SHALL store a completion only when holding is empty or a transfer occurs at the same edge; back-to-back words at full byte rate with WReady=1 SHALL lose nothing.
REQ-022 SHALL, when a completion occurs while WValid=1 and WReady=0, drop the new word, set OvfErr=1, and leave OWord/WValid unchanged.
REQ-023 SHALL hold OWord stable while WValid=1 and WReady=0.
REQ-024 SHALL keep OvfErr set until reset.
REQ-025 SHALL ignore WReady when WValid=0.
REQ-026 SHALL drive Fill, Busy and OvfErr from registers or from register-only logic.

Reset
REQ-027 SHALL, with RSTN=0, immediately set OWord=0, WValid=0, Fill=0, packer bytes=0, OvfErr=0; Busy=0 follows.
REQ-028 SHALL discard any partial or held word on reset mid-operation; the first ENIn after release goes to slot 0.

Structure
REQ-029 SHALL take BYTE_W=8, WORD_BYTES=4 and the Fill width constant from shared package obuf_pkg, alongside the input-buffer constants.
REQ-030 SHALL be a single module with no sub-modules; the packer and holding register are too small to split.

Verification
REQ-031 SHALL cover: ENIn on 4 cycles with 11,22,33,44 and WReady=1 -> OWord=0x11223344 with WValid high for 1 cycle, then Fill=0.
REQ-032 SHALL cover: 8 consecutive bytes 01..08 with WReady=1 -> 0x01020304 then 0x05060708 on consecutive WValid cycles, OvfErr=0.
REQ-033 SHALL cover: bytes AA,BB then Flush -> OWord=0xAABB0000; Flush with ENIn on byte CC after AA,BB -> 0xAABBCC00.
REQ-034 SHALL cover: WReady=0 while 8 bytes stream -> first word held stable, second dropped, OvfErr=1, and the first word is accepted when WReady rises.
REQ-035 SHALL cover: RSTN low after 2 bytes with WValid=1 -> all outputs 0; next bytes 01..04 -> 0x01020304.
REQ-036 SHALL cover: Flush with Fill=0 and ENIn=0 -> no WValid, Busy stays 0.
